video_timing_gen: RTL
=====================

# video_timing_gen

Free-running raster timing generator for the pixel-clock domain. Produces the `hcount`/`vcount` raster coordinates consumed by the sprite and image stages, plus HDMI-style sync, active-video and frame markers. Also produces copies of the sync/active signals delayed by a parameterised number of cycles, so they stay aligned with the pixel output of downstream pipelined stages (4 cycles for the BRAM-backed sprite path).

## Interface
Parameters:
- `ACTIVE_H`, 1280, active pixels per line
- `H_FP`, 110, horizontal front porch (cycles)
- `H_SYNC`, 40, horizontal sync width
- `H_BP`, 220, horizontal back porch
- `ACTIVE_V`, 720, active lines per frame
- `V_FP`, 5, vertical front porch (lines)
- `V_SYNC`, 5, vertical sync width
- `V_BP`, 20, vertical back porch
- `SYNC_DELAY`, 4, pipeline depth of the `*_dly` outputs; legal range 1..8

Ports:
- `pixel_clk_in`  in  1  pixel clock; all logic on its rising edge
- `rst_in`  in  1  synchronous, active-high reset
- `hcount_out`  out  11  horizontal position, 0..TOTAL_H-1
- `vcount_out`  out  10  vertical position, 0..TOTAL_V-1
- `hsync_out`  out  1  horizontal sync, active high
- `vsync_out`  out  1  vertical sync, active high
- `active_draw_out`  out  1  high when the current (hcount, vcount) is inside the active area
- `new_frame_out`  out  1  one-cycle pulse at start of vertical blanking
- `frame_count_out`  out  6  frame counter, wraps
- `hsync_dly_out`, `vsync_dly_out`, `active_draw_dly_out`  out  1 each  the three signals above delayed by SYNC_DELAY cycles

## Operation
- Derived constants:
  - TOTAL_H = ACTIVE_H+H_FP+H_SYNC+H_BP (1650 by default).
  - TOTAL_V = ACTIVE_V+V_FP+V_SYNC+V_BP (750 by default).
- Region order on each axis: active, front porch, sync, back porch.
- Counters:
  - `hcount` increments every cycle; at TOTAL_H-1 it wraps to 0.
  - `vcount` increments only on the cycle `hcount` wraps; at TOTAL_V-1 (coinciding with an hcount wrap) it wraps to 0.
- All status outputs are a registered decode of the counter values, so they always describe the `hcount_out`/`vcount_out` presented in the same cycle:
  - hsync = ACTIVE_H+H_FP ≤ hcount < ACTIVE_H+H_FP+H_SYNC (1390..1429 by default).
  - vsync = ACTIVE_V+V_FP ≤ vcount < ACTIVE_V+V_FP+V_SYNC (725..729 by default). Asserted for the whole line, independent of hcount.
  - active_draw = hcount < ACTIVE_H && vcount < ACTIVE_V.
  - new_frame = hcount==ACTIVE_H && vcount==ACTIVE_V. Exactly one cycle per frame.
  - frame_count increments by 1 in the cycle new_frame is high; 63 wraps to 0.
- Delay line:
  - `*_dly_out` come from a SYNC_DELAY-deep shift register fed with the registered hsync/vsync/active_draw.
  - Output at cycle t equals the undelayed output at cycle t−SYNC_DELAY.
- Reset:
  - While rst_in=1: hcount=TOTAL_H-1, vcount=TOTAL_V-1, frame_count=0, and every other output and every delay-stage register = 0.
  - The reset values decode to 0 under the rules above, so outputs stay self-consistent.
- Reset mid-frame: takes effect on the next edge and overrides all counting. No partial sync pulse survives in the delay line.

## Timing
- First rising edge with rst_in=0: hcount=0, vcount=0, active_draw=1. Pixel (0,0) of frame 0 is therefore presented one cycle after reset release.
- Frame period = TOTAL_H×TOTAL_V cycles (1,237,500 by default). hsync period = TOTAL_H cycles.
- Counter to status: zero cycles of skew. Status to `*_dly`: exactly SYNC_DELAY cycles.
- After reset deasserts, `*_dly` outputs are 0 for the first SYNC_DELAY cycles, then 1 (active_draw_dly) at cycle SYNC_DELAY.
- Width rules:
  - hcount is 11 bits, so TOTAL_H ≤ 2048; vcount is 10 bits, so TOTAL_V ≤ 1024.
  - Comparisons use these widths with no truncation.

## Test plan
- Reset and release: hold rst_in 3 cycles, then check `hcount_out`=1649, `vcount_out`=749 and all flags 0. On the first edge after release: (0,0) with active_draw=1.
- Line wrap: advance to hcount=1649, vcount=0 -> next cycle (0,1). active_draw falls at hcount=1280 and rises again at hcount=0.
- hsync window: on line 3, hsync is high exactly for hcount 1390..1429 (40 cycles) and low at 1389 and 1430.
- Frame boundary: check new_frame is a single pulse at (1280,720). On that pulse frame_count goes 0→1. vsync is high for lines 725..729 only. (1649,749) is followed by (0,0).
- frame_count wrap, using small parameters (ACTIVE_H=8, H_FP=H_SYNC=H_BP=2, ACTIVE_V=4, V_FP=V_SYNC=V_BP=1): run 64 frames -> count 63→0. Frame period is 14×7 = 98 cycles.
- Delay alignment and mid-frame reset: with SYNC_DELAY=4, active_draw_dly equals active_draw shifted by 4 cycles. Assert rst_in for 1 cycle while hsync=1 -> all `*_dly` outputs are 0 for 4 cycles after release.

Source files
------------

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: hcount/vcount, sync, active-video and
// frame markers, plus sync/active copies delayed to match downstream pipelines.
module video_timing_gen #(
    parameter int ACTIVE_H   = 1280,
    parameter int H_FP       = 110,
    parameter int H_SYNC     = 40,
    parameter int H_BP       = 220,
    parameter int ACTIVE_V   = 720,
    parameter int V_FP       = 5,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 20,
    parameter int SYNC_DELAY = 4
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        active_draw_out,
    output logic        new_frame_out,
    output logic [5:0]  frame_count_out,
    output logic        hsync_dly_out,
    output logic        vsync_dly_out,
    output logic        active_draw_dly_out
);

    localparam int TOTAL_H = ACTIVE_H + H_FP + H_SYNC + H_BP;
    localparam int TOTAL_V = ACTIVE_V + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(TOTAL_H - 1);
    localparam logic [9:0]  V_LAST = 10'(TOTAL_V - 1);

    // Decode thresholds are one bit wider than the counters so that a window
    // ending exactly at 2048/1024 still compares correctly.
    localparam logic [11:0] H_ACT_END  = 12'(ACTIVE_H);
    localparam logic [11:0] H_SYNC_BEG = 12'(ACTIVE_H + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(ACTIVE_H + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END  = 11'(ACTIVE_V);
    localparam logic [10:0] V_SYNC_BEG = 11'(ACTIVE_V + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(ACTIVE_V + V_FP + V_SYNC);

    logic [10:0] r_hcount;
    logic [9:0]  r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_active;
    logic        r_new_frame;
    logic [5:0]  r_frame_count;
    logic [2:0]  r_sync_pipe [SYNC_DELAY];

    logic        w_h_wrap;
    logic [10:0] w_h_next;
    logic [9:0]  w_v_next;
    logic [11:0] w_h_ext;
    logic [10:0] w_v_ext;
    logic        w_hsync_next;
    logic        w_vsync_next;
    logic        w_active_next;
    logic        w_new_frame_next;

    // Status flags decode the next counter values so they register together
    // with the counters and never skew against them.
    always_comb begin
        w_h_wrap = (r_hcount == H_LAST);
        w_h_next = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
        w_v_next = r_vcount;
        if (w_h_wrap) begin
            w_v_next = (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
        end
        w_h_ext          = {1'b0, w_h_next};
        w_v_ext          = {1'b0, w_v_next};
        w_hsync_next     = (w_h_ext >= H_SYNC_BEG) && (w_h_ext < H_SYNC_END);
        w_vsync_next     = (w_v_ext >= V_SYNC_BEG) && (w_v_ext < V_SYNC_END);
        w_active_next    = (w_h_ext < H_ACT_END) && (w_v_ext < V_ACT_END);
        w_new_frame_next = (w_h_ext == H_ACT_END) && (w_v_ext == V_ACT_END);
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_hcount      <= H_LAST;
            r_vcount      <= V_LAST;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_active      <= 1'b0;
            r_new_frame   <= 1'b0;
            r_frame_count <= 6'd0;
        end else begin
            r_hcount    <= w_h_next;
            r_vcount    <= w_v_next;
            r_hsync     <= w_hsync_next;
            r_vsync     <= w_vsync_next;
            r_active    <= w_active_next;
            r_new_frame <= w_new_frame_next;
            if (w_new_frame_next) begin
                r_frame_count <= r_frame_count + 6'd1;
            end
        end
    end

    // Delay line is cleared on reset so no partial sync pulse survives it.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < SYNC_DELAY; i++) begin
                r_sync_pipe[i] <= 3'b000;
            end
        end else begin
            r_sync_pipe[0] <= {r_active, r_vsync, r_hsync};
            for (int i = 1; i < SYNC_DELAY; i++) begin
                r_sync_pipe[i] <= r_sync_pipe[i-1];
            end
        end
    end

    assign hcount_out          = r_hcount;
    assign vcount_out          = r_vcount;
    assign hsync_out           = r_hsync;
    assign vsync_out           = r_vsync;
    assign active_draw_out     = r_active;
    assign new_frame_out       = r_new_frame;
    assign frame_count_out     = r_frame_count;
    assign hsync_dly_out       = r_sync_pipe[SYNC_DELAY-1][0];
    assign vsync_dly_out       = r_sync_pipe[SYNC_DELAY-1][1];
    assign active_draw_dly_out = r_sync_pipe[SYNC_DELAY-1][2];

endmodule
